// File: rtl/bus_pkg.sv
// Shared types and default address map for the CPU data-port interconnect.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } Bus_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } Bus_op_t;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;

  // Request as seen on the default 32-bit CPU data port.
  typedef struct packed {
    Bus_op_t                     op;
    logic [BUS_ADDR_W-1:0]       addr;
    logic [BUS_DATA_W-1:0]       data;
    logic [BUS_DATA_W/8-1:0]     mask;
  } Bus_req_t;

  localparam logic [BUS_ADDR_W-1:0] SRAM0_BASE  = 32'h8000_0000;
  localparam logic [BUS_ADDR_W-1:0] SRAM1_BASE  = 32'h8040_0000;
  localparam logic [BUS_ADDR_W-1:0] SRAM_MASK   = 32'h003f_ffff;
  localparam logic [BUS_ADDR_W-1:0] SERIAL_BASE = 32'hBFD0_03F8;
  localparam logic [BUS_ADDR_W-1:0] SERIAL_MASK = 32'h0000_0007;
  localparam logic [BUS_ADDR_W-1:0] VGA_BASE    = 32'hBA00_0000;
  localparam logic [BUS_ADDR_W-1:0] VGA_MASK    = 32'h00ff_ffff;

endpackage

// File: rtl/addr_decoder.sv
// Combinational address map lookup: hit flag, slave index and masked offset.
module addr_decoder #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned SEL_W      = 2,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic [ADDR_W-1:0] offset_o
);

  logic found;

  // First match in index order wins, so overlapping regions favour lower slaves.
  always_comb begin
    found    = 1'b0;
    sel_o    = '0;
    offset_o = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!found && ((addr_i & ~SLAVE_MASK[i]) == SLAVE_BASE[i])) begin
        found    = 1'b1;
        sel_o    = SEL_W'(i);
        offset_o = addr_i & SLAVE_MASK[i];
      end
    end
  end

  assign hit_o = found;

endmodule

// File: rtl/bus_interconnect.sv
// Single-master, multi-slave registered request/acknowledge interconnect with
// configurable address map, error response for unmapped/illegal accesses and timeout.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLAVE_MASK = {NUM_SLAVES{ADDR_W'(32'h000f_ffff)}},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_read_op,
  input  logic                         m_write_op,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_data_write,
  input  logic [DATA_W/8-1:0]          m_byte_mask,
  output logic [DATA_W-1:0]            m_data_read,
  output logic                         m_ack,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_read_op,
  output logic [NUM_SLAVES-1:0]        s_write_op,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_data_write,
  output logic [DATA_W/8-1:0]          s_byte_mask,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_data_read,
  input  logic [NUM_SLAVES-1:0]        s_ack
);

  localparam int unsigned SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef struct packed {
    Bus_op_t             op;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [MASK_W-1:0]   mask;
  } req_t;

  Bus_state_t          state_q, state_d;
  req_t                req_q, req_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                dec_hit;
  logic [SEL_W-1:0]    dec_sel;
  logic [ADDR_W-1:0]   dec_offset;

  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdata;
  logic [NUM_SLAVES-1:0] sel_onehot;

  addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SEL_W      (SEL_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .addr_i   (m_addr),
    .hit_o    (dec_hit),
    .sel_o    (dec_sel),
    .offset_o (dec_offset)
  );

  // Only the selected slave's ack and data are visible; all others are ignored.
  always_comb begin
    sel_ack    = 1'b0;
    sel_rdata  = '0;
    sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ack       = s_ack[i];
        sel_rdata     = s_data_read[i*DATA_W +: DATA_W];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (m_read_op || m_write_op) begin
          req_d.op   = m_write_op ? OP_WRITE : OP_READ;
          req_d.addr = dec_offset;
          req_d.data = m_data_write;
          req_d.mask = m_byte_mask;
          cnt_d      = '0;
          if ((m_read_op && m_write_op) || !dec_hit) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            sel_d   = dec_sel;
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        // Ack is tested first so it wins over a coincident timeout.
        if (sel_ack) begin
          err_d = 1'b0;
          if (req_q.op == OP_READ) begin
            rdata_d = sel_rdata;
          end
          state_d = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode straight from registered state so reset removes them immediately.
  assign s_read_op    = ((state_q == BUSY) && (req_q.op == OP_READ))  ? sel_onehot : '0;
  assign s_write_op   = ((state_q == BUSY) && (req_q.op == OP_WRITE)) ? sel_onehot : '0;
  assign s_addr       = req_q.addr;
  assign s_data_write = req_q.data;
  assign s_byte_mask  = req_q.mask;

  assign m_ack       = (state_q == RESP);
  assign m_err       = (state_q == RESP) && err_q;
  assign m_data_read = rdata_q;

endmodule

// File: tb/tb_bus_interconnect.sv
// Randomised scoreboard bench for bus_interconnect with behavioural slave models.
module tb_bus_interconnect;

  localparam int NS = 4;
  localparam int TO = 8;
  localparam logic [NS-1:0][31:0] BASE = {32'hBFD0_0000, 32'hBA00_0000, 32'hBFD0_0000, 32'h8040_0000};
  localparam logic [NS-1:0][31:0] MASK = {32'h0000_FFFF, 32'h00FF_FFFF, 32'h0000_0FFF, 32'h003F_FFFF};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            m_read_op, m_write_op;
  logic [31:0]     m_addr, m_data_write, m_data_read;
  logic [3:0]      m_byte_mask;
  logic            m_ack, m_err;
  logic [NS-1:0]   s_read_op, s_write_op, s_ack;
  logic [31:0]     s_addr, s_data_write;
  logic [3:0]      s_byte_mask;
  logic [NS*32-1:0] s_data_read;

  bus_interconnect #(
    .NUM_SLAVES     (NS),
    .ADDR_W         (32),
    .DATA_W         (32),
    .SLAVE_BASE     (BASE),
    .SLAVE_MASK     (MASK),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .m_read_op    (m_read_op),
    .m_write_op   (m_write_op),
    .m_addr       (m_addr),
    .m_data_write (m_data_write),
    .m_byte_mask  (m_byte_mask),
    .m_data_read  (m_data_read),
    .m_ack        (m_ack),
    .m_err        (m_err),
    .s_read_op    (s_read_op),
    .s_write_op   (s_write_op),
    .s_addr       (s_addr),
    .s_data_write (s_data_write),
    .s_byte_mask  (s_byte_mask),
    .s_data_read  (s_data_read),
    .s_ack        (s_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    bit          is_wr;
    bit          err;
    logic [31:0] data;
    logic [31:0] offset;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          lat;
    int          scyc;
    int          e_edge;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          edges  = 0;
  int          slv_lat = 0;
  logic [31:0] slv_data = '0;
  int          scnt = 0;
  int          mon_scyc = 0;
  logic [31:0] last_rdata = '0;
  int          ack_p = 0;
  bit          abort = 1'b0;

  always @(posedge clk) edges++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & ~MASK[i]) == BASE[i]) return i;
    return -1;
  endfunction

  // Slaves: the strobed one acks in its slv_lat-th strobe cycle (0 = never);
  // unselected slaves emit random spurious acks and random read data.
  always @(negedge clk) begin : slaves
    logic [NS-1:0] stb;
    stb = s_read_op | s_write_op;
    if (rst) begin
      scnt  = 0;
      s_ack = '0;
    end else begin
      if (stb != '0) scnt++;
      else scnt = 0;
      for (int j = 0; j < NS; j++) begin
        s_data_read[j*32 +: 32] = $urandom;
        if (stb[j]) begin
          s_ack[j] = (scnt == slv_lat);
          if (scnt == slv_lat) s_data_read[j*32 +: 32] = slv_data;
        end else begin
          s_ack[j] = ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t          e;
    logic [NS-1:0] er, ew;
    if (rst) begin
      mon_scyc = 0;
    end else begin
      if ((s_read_op | s_write_op) != '0) begin
        mon_scyc++;
        if (exp_q.size() == 0) begin
          check("strobe_when_idle", 64'({s_read_op, s_write_op}), 64'(0));
        end else begin
          e  = exp_q[0];
          er = '0;
          ew = '0;
          if (e.sel >= 0) begin
            if (e.is_wr) ew[e.sel] = 1'b1;
            else         er[e.sel] = 1'b1;
          end
          check("strobe", 64'({s_read_op, s_write_op}), 64'({er, ew}));
          check("s_addr", 64'(s_addr), 64'(e.offset));
          if (e.is_wr) begin
            check("s_data_write", 64'(s_data_write), 64'(e.wdata));
            check("s_byte_mask", 64'(s_byte_mask), 64'(e.mask));
          end
        end
      end
      if (m_ack) begin
        if (exp_q.size() == 0) begin
          check("m_ack_unexpected", 64'(m_ack), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("m_err", 64'(m_err), 64'(e.err));
          check("m_data_read", 64'(m_data_read), 64'(e.data));
          check("ack_latency", 64'(edges + 1 - e.e_edge), 64'(e.lat));
          check("strobe_cycles", 64'(mon_scyc), 64'(e.scyc));
        end
        mon_scyc = 0;
      end else if (m_err) begin
        check("m_err_without_ack", 64'(m_err), 64'(0));
      end
    end
  end

  // gap==0 keeps the request asserted through RESP; it is taken two edges after the ack edge.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] mask,
                         input int lat, input int gap);
    exp_t e;
    int   sel;
    bit   got;
    if (abort) return;
    if (gap == 0) begin
      e.e_edge = ack_p + 2;
    end else begin
      m_read_op  = 1'b0;
      m_write_op = 1'b0;
      repeat (gap) @(negedge clk);
      e.e_edge = edges + 1;
    end
    sel     = model_decode(addr);
    e.is_wr = wr;
    e.wdata = data;
    e.mask  = mask;
    if ((rd && wr) || sel < 0) begin
      e.sel = -1; e.err = 1'b1; e.data = '0; e.offset = '0; e.lat = 1; e.scyc = 0;
    end else begin
      e.sel    = sel;
      e.offset = addr & MASK[sel];
      if (lat >= 1 && lat <= TO + 1) begin
        e.err = 1'b0; e.data = wr ? last_rdata : data; e.lat = lat + 1; e.scyc = lat;
      end else begin
        e.err = 1'b1; e.data = '0; e.lat = TO + 2; e.scyc = TO + 1;
      end
    end
    last_rdata = e.data;
    exp_q.push_back(e);
    slv_lat      = lat;
    slv_data     = data;
    m_read_op    = rd;
    m_write_op   = wr;
    m_addr       = addr;
    m_data_write = data;
    m_byte_mask  = mask;
    got = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (m_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("m_ack_timeout", 64'(m_ack), 64'(1));
      abort = 1'b1;
    end
    ack_p = edges;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    exp_t        re;
    int          k, r, r2, lat, gap;
    logic [31:0] a;
    bit          rd, wr;

    m_read_op = 1'b0; m_write_op = 1'b0; m_addr = '0;
    m_data_write = '0; m_byte_mask = '0;
    s_ack = '0; s_data_read = '0;
    repeat (2) @(negedge clk);
    check("reset_m_side", 64'({m_ack, m_err, m_data_read}), 64'(0));
    check("reset_strobes", 64'({s_read_op, s_write_op}), 64'(0));
    check("reset_s_side", 64'({s_addr, s_byte_mask}), 64'(0));
    rst = 1'b0;

    run_txn(1'b1, 1'b0, 32'h8040_0010, 32'hDEAD_BEEF, 4'hF, 4, 1);
    run_txn(1'b0, 1'b1, 32'hBA00_0100, 32'h1234_5678, 4'b0011, 2, 0);
    run_txn(1'b1, 1'b0, 32'h0000_0004, 32'h1111_1111, 4'hF, 1, 1);
    run_txn(1'b1, 1'b0, 32'h8040_0ABC, 32'h2222_2222, 4'hF, 0, 1);
    run_txn(1'b1, 1'b0, 32'hBFD0_0008, 32'h3333_3333, 4'hF, 1, 0);
    run_txn(1'b1, 1'b1, 32'h8040_0000, 32'h9999_9999, 4'hF, 1, 1);
    run_txn(1'b1, 1'b0, 32'h8040_0004, 32'h4444_4444, 4'hF, TO + 1, 1);
    run_txn(1'b1, 1'b0, 32'hBFD0_1004, 32'h5555_5555, 4'hF, 2, 0);
    run_txn(1'b0, 1'b1, 32'h8040_0008, 32'h6666_6666, 4'hC, 1, 1);

    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, 4);
      a  = (k < NS) ? (BASE[k] | ($urandom & MASK[k])) : ($urandom & 32'h0FFF_FFFF);
      r  = $urandom_range(0, 9);
      rd = (r == 0) || (r < 6);
      wr = (r == 0) || (r >= 6);
      r2 = $urandom_range(0, 9);
      lat = (r2 == 0) ? 0 : ((r2 == 1) ? TO + 1 : $urandom_range(1, 5));
      gap = $urandom_range(0, 2);
      run_txn(rd, wr, a, $urandom, 4'($urandom_range(0, 15)), lat, gap);
    end

    // Reset in the middle of a write to a hung slave.
    run_txn(1'b1, 1'b0, 32'hBA00_0044, 32'hCAFE_F00D, 4'hF, 1, 1);
    if (!abort) begin
      m_read_op = 1'b0; m_write_op = 1'b0;
      @(negedge clk);
      re.sel = 0; re.is_wr = 1'b1; re.err = 1'b1; re.data = '0; re.offset = 32'h20;
      re.wdata = 32'h5555_AAAA; re.mask = 4'hF; re.lat = TO + 2; re.scyc = TO + 1;
      re.e_edge = edges + 1;
      exp_q.push_back(re);
      slv_lat = 0;
      m_write_op = 1'b1; m_addr = BASE[0] | 32'h20;
      m_data_write = 32'h5555_AAAA; m_byte_mask = 4'hF;
      repeat (3) @(negedge clk);
      check("pre_reset_strobe", 64'(s_write_op), 64'(4'b0001));
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_busy_m_side", 64'({m_ack, m_err, m_data_read}), 64'(0));
      check("rst_busy_strobes", 64'({s_read_op, s_write_op}), 64'(0));
      check("rst_busy_s_addr", 64'(s_addr), 64'(0));
      check("rst_busy_s_wdata", 64'({s_data_write, s_byte_mask}), 64'(0));
      exp_q.delete();
      m_write_op = 1'b0;
      last_rdata = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_txn(1'b0, 1'b1, 32'hBA00_0010, 32'h0BAD_CAFE, 4'h5, 1, 1);
      run_txn(1'b1, 1'b0, 32'hBFD0_03F8, 32'h7777_8888, 4'hF, 3, 0);
    end

    m_read_op = 1'b0; m_write_op = 1'b0;
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
